// File: rtl/bcd_timer_pkg.sv
// -----------------------------------------------------------------------------
// bcd_timer_pkg
// Shared types and constants for the BCD stopwatch / countdown sequencer.
//   bcd_state_t : sequencer states
//   BCD_W       : bits per BCD digit
//   BCD_MAX     : largest legal BCD digit value
//   bcd_clamp() : saturate a digit to 9
//   bcd_bad()   : flag a non-BCD digit (10..15)
// -----------------------------------------------------------------------------
package bcd_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    RUN,
    PAUSE,
    EXPIRE
  } bcd_state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

  function automatic logic bcd_bad(input logic [BCD_W-1:0] v);
    return (v > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_tick_gen.sv
// -----------------------------------------------------------------------------
// bcd_tick_gen
// Prescaler producing one TICK every PRESCALE cycles while RUN is high.
// The count is frozen while RUN is low, so a paused timer resumes mid-period.
// Ports:
//   CLK   in  : clock, rising edge
//   CLR_N in  : synchronous active-low reset (count -> 0)
//   RUN   in  : advance the count this cycle
//   CLEAR in  : force the count to 0 (has priority over RUN)
//   TICK  out : high in the cycle the count sits at PRESCALE-1 with RUN high
// -----------------------------------------------------------------------------
module bcd_tick_gen #(
  parameter int PRESCALE = 100
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic RUN,
  input  logic CLEAR,
  output logic TICK
);

  localparam int            CW   = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      cnt_q <= '0;
    end else if (CLEAR) begin
      cnt_q <= '0;
    end else if (RUN) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign TICK = RUN && (cnt_q == LAST);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_timer_ctrl
// Sequencer for a chain of NDIG binary digit counters, turning them into a
// decimal stopwatch (MODE_UP=1) or countdown timer (MODE_UP=0). On every
// prescaled tick it emits one registered cycle of per-digit ENABLE/LOAD/D
// commands plus a shared UP; decimal wrap is done by loading 0 or 9.
//
// Configuration macro: BCD_TIMER_CTRL_WRAP_EN
//   defined   : an all-nines up tick reloads 0000.., pulses DONE, keeps running
//   undefined : an all-nines up tick saturates and expires (DONE, back to IDLE)
//
// Ports:
//   CLK      in  : clock, rising edge
//   CLR_N    in  : synchronous active-low reset
//   START    in  : start from IDLE / resume from PAUSE
//   STOP     in  : pause from RUN / abort from PAUSE (wins over START)
//   MODE_UP  in  : 1 = stopwatch, 0 = countdown (latched on start)
//   PRESET   in  : countdown start value, digit i at [4i+3:4i]
//   Q_IN     in  : current digit values from the counters
//   DIG_EN   out : per-digit ENABLE
//   DIG_LOAD out : per-digit LOAD
//   DIG_UP   out : shared count direction
//   DIG_D    out : per-digit load data
//   DIG_CLR  out : shared counter clear pulse
//   BUSY     out : high in PRELOAD, RUN, PAUSE
//   DONE     out : pulse on expiry or wrap
//   ERR      out : pulse when a non-BCD digit was corrected
// -----------------------------------------------------------------------------
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int DWL      = 4,
  parameter int PRESCALE = 100
) (
  input  logic                CLK,
  input  logic                CLR_N,
  input  logic                START,
  input  logic                STOP,
  input  logic                MODE_UP,
  input  logic [NDIG*DWL-1:0] PRESET,
  input  logic [NDIG*DWL-1:0] Q_IN,
  output logic [NDIG-1:0]     DIG_EN,
  output logic [NDIG-1:0]     DIG_LOAD,
  output logic                DIG_UP,
  output logic [NDIG*DWL-1:0] DIG_D,
  output logic                DIG_CLR,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  bcd_state_t          state_q;
  logic                mode_q;
  logic [NDIG-1:0]     dig_en_q;
  logic [NDIG-1:0]     dig_load_q;
  logic                dig_up_q;
  logic [NDIG*DWL-1:0] dig_d_q;
  logic                dig_clr_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic                tick;
  logic                run_cnt;
  logic                clr_cnt;

  // Per-digit tick command, derived from Q_IN and the latched mode.
  logic [NDIG-1:0]     is_bad;
  logic [NDIG-1:0]     is_zero;
  logic [NDIG-1:0]     is_nine;
  logic [NDIG-1:0]     prop;      // digit passes carry/borrow upward
  logic [NDIG-1:0]     chain;     // every lower digit propagates
  logic [NDIG-1:0]     tick_en;
  logic [NDIG-1:0]     tick_load;
  logic [NDIG*DWL-1:0] tick_d;
  logic [NDIG*DWL-1:0] preload_d;
  logic                all_zero;
  logic                all_nine;

  // STOP gates the prescaler in the same cycle it is sampled, so the count
  // seen at the STOP edge is exactly the one resumed from.
  assign run_cnt = (state_q == RUN) && !STOP;
  assign clr_cnt = (state_q == PRELOAD);

  bcd_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .RUN   (run_cnt),
    .CLEAR (clr_cnt),
    .TICK  (tick)
  );

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    logic [DWL-1:0] q;
    assign q = Q_IN[i*DWL +: DWL];

    assign is_bad[i]  = bcd_bad(q);
    assign is_zero[i] = (q == '0);
    assign is_nine[i] = (q == BCD_MAX);

    // A non-BCD digit behaves as 9 (up) or 0 (down) for the digits above it.
    assign prop[i] = is_bad[i] | (mode_q ? is_nine[i] : is_zero[i]);

    if (i == 0) begin : g_lsd
      assign chain[i] = 1'b1;
    end else begin : g_upper
      assign chain[i] = chain[i-1] & prop[i-1];
    end

    // A corrupt digit is always reloaded with 0, enabled or not.
    assign tick_en[i]   = chain[i] | is_bad[i];
    assign tick_load[i] = is_bad[i] | (chain[i] & (mode_q ? is_nine[i] : is_zero[i]));
    assign tick_d[i*DWL +: DWL] =
      (tick_load[i] && !is_bad[i] && !mode_q) ? BCD_MAX : '0;

    assign preload_d[i*DWL +: DWL] = MODE_UP ? '0 : bcd_clamp(PRESET[i*DWL +: DWL]);
  end

  assign all_zero = &is_zero;
  assign all_nine = &is_nine;

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      dig_en_q   <= '0;
      dig_load_q <= '0;
      dig_up_q   <= 1'b0;
      dig_d_q    <= '0;
      dig_clr_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Command outputs are single-cycle pulses: cleared every cycle unless
      // the branch below asserts them.
      dig_en_q   <= '0;
      dig_load_q <= '0;
      dig_up_q   <= 1'b0;
      dig_d_q    <= '0;
      dig_clr_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;

      case (state_q)
        IDLE: begin
          if (START && !STOP) begin
            mode_q     <= MODE_UP;
            state_q    <= PRELOAD;
            dig_en_q   <= '1;
            dig_load_q <= '1;
            dig_d_q    <= preload_d;
            busy_q     <= 1'b1;
          end
        end

        PRELOAD: begin
          state_q <= RUN;
        end

        RUN: begin
          if (STOP) begin
            state_q <= PAUSE;
          end else if (tick) begin
            if (!mode_q && all_zero) begin
              state_q <= EXPIRE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (mode_q && all_nine) begin
`ifdef BCD_TIMER_CTRL_WRAP_EN
              dig_en_q   <= '1;
              dig_load_q <= '1;
              dig_up_q   <= 1'b1;
              dig_d_q    <= '0;
              done_q     <= 1'b1;
`else
              state_q <= EXPIRE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
`endif
            end else begin
              dig_en_q   <= tick_en;
              dig_load_q <= tick_load;
              dig_up_q   <= mode_q;
              dig_d_q    <= tick_d;
              err_q      <= |is_bad;
            end
          end
        end

        PAUSE: begin
          if (STOP) begin
            state_q   <= IDLE;
            dig_clr_q <= 1'b1;
            busy_q    <= 1'b0;
          end else if (START) begin
            state_q <= RUN;
          end
        end

        EXPIRE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DIG_EN   = dig_en_q;
  assign DIG_LOAD = dig_load_q;
  assign DIG_UP   = dig_up_q;
  assign DIG_D    = dig_d_q;
  assign DIG_CLR  = dig_clr_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

endmodule
